ser_sub64: RTL and testbench
============================

Name: ser_sub64

Overview:
- Multi-cycle, digit-serial 64-bit subtractor: D = A - B - bin.
- Sibling of the team's carry-ripple adder family, working in the inverse arithmetic direction.
- Reuses one W-bit ripple-borrow slice over N/W cycles to trade latency for area.
- Sits behind a valid/ready request interface and presents its result on a valid/ready response interface.

Parameters:
- N, 64, operand/result width in bits.
- W, 8, slice width processed per cycle. N must be a multiple of W; W >= 1.
- S, N/W (derived localparam), number of slices and cycles per operation.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset; one clock domain only.
- in_valid  input  1  request valid.
- in_ready  output  1  block can accept a request; high only in IDLE.
- a  input  N  minuend, sampled on accept.
- b  input  N  subtrahend, sampled on accept.
- bin  input  1  borrow-in, sampled on accept.
- out_valid  output  1  result valid; high only in DONE.
- out_ready  input  1  consumer accepts result.
- d  output  N  difference, a - b - bin mod 2^N.
- bout  output  1  borrow-out: 1 iff a < b + bin (unsigned).
- ovf  output  1  signed overflow: a[N-1] != b[N-1] and d[N-1] != a[N-1].

Behaviour:
- Reset (async assert, sync release on the next clk edge):
  - state = IDLE; in_ready = 1; out_valid = 0; d = 0; bout = 0; ovf = 0.
  - Internal operand registers, borrow register and slice counter are cleared.
- FSM has three states: IDLE, BUSY, DONE.
- IDLE:
  - in_ready = 1.
  - On in_valid && in_ready at edge T: latch a, b and bin (bin goes into the borrow register).
  - Clear the slice counter k to 0 and go to BUSY.
- BUSY:
  - in_ready = 0; in_valid is ignored.
  - On each edge, compute slice k: {brw, d[k*W +: W]} = a[k*W +: W] - b[k*W +: W] - brw_reg.
  - Update brw_reg and increment k.
  - On the edge where k = S-1:
    - write the final slice;
    - bout = final borrow;
    - ovf = computed from the MSBs of a, b and the final d;
    - go to DONE.
- DONE:
  - out_valid = 1.
  - d, bout and ovf are held stable until out_valid && out_ready.
  - On that handshake edge go to IDLE. out_valid drops and in_ready rises in the next cycle.
  - No overlap: a new request cannot be accepted in the same cycle as a result handshake.
- Latency: out_valid is first high after edge T+S, where T is the accepting edge. With defaults, 8 edges after accept.
- Throughput: one operation per S+2 cycles minimum, assuming out_ready is held high.
- d is only meaningful while out_valid = 1:
  - during BUSY it holds partial results;
  - it retains the last result in IDLE;
  - the bench must check d only on the handshake.
- Input operands may change freely after the accepting edge; internal copies are used.
- Reset asserted mid-BUSY or in DONE:
  - aborts immediately to reset values;
  - no result is produced;
  - in_ready = 1 after release.
- W = N degenerates to single-cycle compute: S = 1, so BUSY lasts exactly one edge.
- No X propagation: unused internal bits are driven to 0.

Test Plan:
- a=10, b=3, bin=0 -> d=7, bout=0, ovf=0; out_valid first high exactly 8 edges after accept; in_ready low throughout.
- a=0, b=1, bin=0 -> d=0xFFFF_FFFF_FFFF_FFFF, bout=1, ovf=0 (borrow ripples through all 8 slices).
- a=0x8000_0000_0000_0000, b=1, bin=0 -> d=0x7FFF_FFFF_FFFF_FFFF, bout=0, ovf=1.
- a=5, b=5, bin=1 -> d=0xFFFF_FFFF_FFFF_FFFF, bout=1, ovf=0.
- Back-pressure: hold out_ready=0 for 5 cycles in DONE while pulsing in_valid with a=1, b=1:
  - d, bout and ovf stay stable, in_ready stays 0, and the new request is not accepted;
  - after out_ready=1, one idle cycle follows, then a=1, b=1 is accepted and gives d=0.
- Assert rst_n=0 on the 4th BUSY cycle of a=100, b=1:
  - out_valid, d, bout and ovf go to 0 immediately;
  - in_ready=1 after release;
  - no stale result appears;
  - the next request a=9, b=4 gives d=5.

Source files
------------

// File: rtl/ser_sub64.sv
// Digit-serial subtractor: d = a - b - bin, one W-bit ripple-borrow slice per cycle over S cycles.
// Request/response are valid/ready; the result is held in DONE until the consumer takes it.
module ser_sub64 #(
    parameter int unsigned N = 64,
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         bin,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] d,
    output logic         bout,
    output logic         ovf
);

    localparam int unsigned S  = N / W;
    localparam int unsigned KW = (S > 1) ? $clog2(S) : 1;
    localparam int unsigned W1 = W + 1;
    localparam logic [KW-1:0] KLast     = KW'(S - 1);
    localparam logic [N-1:0]  SliceMask = N'({W{1'b1}});

    typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

    state_e        state_q;
    logic [N-1:0]  a_q, b_q, d_q;
    logic          brw_q, bout_q, ovf_q;
    logic [KW-1:0] k_q;

    int unsigned   base;
    logic [W-1:0]  a_sl, b_sl;
    logic [W:0]    diff;
    logic [N-1:0]  d_next;

    // Slice k is selected by shifting, so W = N needs no special casing.
    always_comb begin
        base   = 32'(k_q) * W;
        a_sl   = W'(a_q >> base);
        b_sl   = W'(b_q >> base);
        diff   = {1'b0, a_sl} - {1'b0, b_sl} - W1'(brw_q);
        d_next = (d_q & ~(SliceMask << base)) | (N'(diff[W-1:0]) << base);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            a_q     <= '0;
            b_q     <= '0;
            d_q     <= '0;
            brw_q   <= 1'b0;
            bout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            k_q     <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (in_valid) begin
                        a_q     <= a;
                        b_q     <= b;
                        brw_q   <= bin;
                        k_q     <= '0;
                        state_q <= StBusy;
                    end
                end
                StBusy: begin
                    d_q   <= d_next;
                    brw_q <= diff[W];
                    k_q   <= k_q + KW'(1);
                    if (k_q == KLast) begin
                        bout_q  <= diff[W];
                        // diff[W-1] is the MSB of the final d.
                        ovf_q   <= (a_q[N-1] != b_q[N-1]) && (diff[W-1] != a_q[N-1]);
                        state_q <= StDone;
                    end
                end
                StDone: begin
                    if (out_ready) begin
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign in_ready  = (state_q == StIdle);
    assign out_valid = (state_q == StDone);
    assign d         = d_q;
    assign bout      = bout_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_ser_sub64.sv
// Scoreboard bench for ser_sub64: directed cases plus random operands against an arithmetic model.
module tb_ser_sub64;

    localparam int unsigned S = 8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] a, b, d;
    logic        bin;
    logic        out_valid, out_ready, bout, ovf;

    logic rand_rdy = 1'b0;
    logic rdy_man  = 1'b1;
    logic rnd_bit  = 1'b1;

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic [63:0] d;
        logic        bout;
        logic        ovf;
    } res_t;

    res_t exp_q[$];

    ser_sub64 dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a        (a),
        .b        (b),
        .bin      (bin),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .d        (d),
        .bout     (bout),
        .ovf      (ovf)
    );

    always #5 clk = ~clk;

    always @(posedge clk) rnd_bit <= 1'($urandom_range(0, 1));
    assign out_ready = rand_rdy ? rnd_bit : rdy_man;

    function automatic res_t model(input logic [63:0] x, input logic [63:0] y, input logic bi);
        res_t r;
        r.d    = x - y - 64'(bi);
        r.bout = ({1'b0, x} < ({1'b0, y} + 65'(bi)));
        r.ovf  = (x[63] != y[63]) && (r.d[63] != x[63]);
        return r;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, want);
        end
    endtask

    // Monitor: pops one expectation per output handshake.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_result", 64'(out_valid), 64'd0);
                end else begin
                    res_t e;
                    e = exp_q.pop_front();
                    chk("d", d, e.d);
                    chk("bout", 64'(bout), 64'(e.bout));
                    chk("ovf", 64'(ovf), 64'(e.ovf));
                end
            end
        end
    end

    task automatic send(input logic [63:0] aa, input logic [63:0] bb, input logic bi,
                        input bit expect_result);
        int n;
        n = 0;
        while (in_ready !== 1'b1 && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (in_ready !== 1'b1) chk("accept_timeout", 64'(in_ready), 64'd1);
        a        = aa;
        b        = bb;
        bin      = bi;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a        = {$urandom, $urandom};
        b        = {$urandom, $urandom};
        bin      = 1'($urandom_range(0, 1));
        if (expect_result) exp_q.push_back(model(aa, bb, bi));
    endtask

    // Called just after the accepting edge; counts edges until out_valid.
    task automatic wait_result();
        int lat;
        bit busy_ok;
        lat     = 0;
        busy_ok = 1'b1;
        while (out_valid !== 1'b1 && lat < 50) begin
            if (in_ready !== 1'b0) busy_ok = 1'b0;
            @(posedge clk);
            #1;
            lat++;
        end
        chk("latency", 64'(lat), 64'(S));
        chk("in_ready_low_busy", 64'(busy_ok), 64'd1);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || out_valid === 1'b1) && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("drain", 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        res_t e;
        bit   quiet;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        a        = '0;
        b        = '0;
        bin      = 1'b0;
        #22;
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_d", d, 64'd0);
        chk("rst_bout", 64'(bout), 64'd0);
        chk("rst_ovf", 64'(ovf), 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        send(64'd10, 64'd3, 1'b0, 1'b1);
        wait_result();
        drain();
        send(64'h8000_0000_0000_0000, 64'd1, 1'b0, 1'b1);
        wait_result();
        drain();

        // Back-pressure: result must hold while a pending request is refused.
        rdy_man = 1'b0;
        send(64'd5, 64'd5, 1'b1, 1'b1);
        wait_result();
        e = model(64'd5, 64'd5, 1'b1);
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'(i % 2 == 0);
            a        = 64'd1;
            b        = 64'd1;
            bin      = 1'b0;
            chk("bp_d", d, e.d);
            chk("bp_bout", 64'(bout), 64'(e.bout));
            chk("bp_ovf", 64'(ovf), 64'(e.ovf));
            chk("bp_in_ready", 64'(in_ready), 64'd0);
            chk("bp_out_valid", 64'(out_valid), 64'd1);
            @(posedge clk);
            #1;
        end
        in_valid = 1'b1;
        rdy_man  = 1'b1;
        @(posedge clk);
        #1;
        chk("bp_idle_in_ready", 64'(in_ready), 64'd1);
        chk("bp_idle_out_valid", 64'(out_valid), 64'd0);
        exp_q.push_back(model(64'd1, 64'd1, 1'b0));
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk("bp_accepted", 64'(in_ready), 64'd0);
        wait_result();
        drain();

        send(64'd0, 64'd1, 1'b0, 1'b1);
        wait_result();
        drain();

        // Reset in the 4th BUSY cycle aborts the operation.
        send(64'd100, 64'd1, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("abort_out_valid", 64'(out_valid), 64'd0);
        chk("abort_d", d, 64'd0);
        chk("abort_bout", 64'(bout), 64'd0);
        chk("abort_ovf", 64'(ovf), 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk("abort_in_ready", 64'(in_ready), 64'd1);
        quiet = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk);
            #1;
            if (out_valid !== 1'b0) quiet = 1'b0;
        end
        chk("abort_no_stale", 64'(quiet), 64'd1);
        send(64'd9, 64'd4, 1'b0, 1'b1);
        wait_result();
        drain();

        // Random operands with random consumer back-pressure.
        rand_rdy = 1'b1;
        for (int i = 0; i < 40; i++) begin
            logic [63:0] ra, rb;
            ra = {$urandom, $urandom};
            rb = {$urandom, $urandom};
            if (i % 8 == 1) rb = ra;
            if (i % 8 == 2) ra = 64'd0;
            if (i % 8 == 3) rb = 64'hFFFF_FFFF_FFFF_FFFF;
            send(ra, rb, 1'($urandom_range(0, 1)), 1'b1);
            wait_result();
        end
        drain();
        rand_rdy = 1'b0;
        repeat (3) @(posedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
